cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 181 ++++++++++++++++++
 tb/tb_cordic_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// -----------------------------------------------------------------------------
// cordic_sched
//   Shares one in-order, fixed-latency CORDIC core among NREQ requesters.
//   A combinational round-robin arbiter picks one requester per cycle. The
//   winner's mode/argument are registered onto the core issue port, and its
//   index is pushed into a tag FIFO. Because the core returns results in issue
//   order, each core result pops the head tag and is steered to that
//   requester's response strobe one cycle later.
//
//   Optional feature macro: CORDIC_SCHED_HIPRIO_EN
//     When defined, requester 0 wins whenever it is valid. Round-robin then
//     applies only among the remaining requesters.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  per-requester handshake (ready is one-hot or zero)
//   req_mode         4-bit function code per requester, slice i = [4i+3:4i]
//   req_arg          32-bit Q16.16 argument per requester, slice i = [32i+31:32i]
//   rsp_valid        one-cycle result strobe per requester (one-hot or zero)
//   rsp_result       result data, qualified by rsp_valid
//   cor_pre_valid    issue strobe to the core
//   cor_mode         function code to the core (holds while idle)
//   cor_angle        argument to the core (holds while idle)
//   cor_result       result from the core
//   cor_post_valid   result strobe from the core
//   inflight         tag-FIFO occupancy
//   err_orphan       sticky: a core result arrived with no outstanding tag
// -----------------------------------------------------------------------------
module cordic_sched #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [4*NREQ-1:0]            req_mode,
  input  logic [32*NREQ-1:0]           req_arg,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [31:0]                  rsp_result,
  output logic                         cor_pre_valid,
  output logic [3:0]                   cor_mode,
  output logic [31:0]                  cor_angle,
  input  logic [31:0]                  cor_result,
  input  logic                         cor_post_valid,
  output logic [$clog2(TAG_DEPTH):0]   inflight,
  output logic                         err_orphan
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [IDX_W-1:0] cand;
  logic [3:0]       sel_mode;
  logic [31:0]      sel_arg;

  logic             full;
  logic             accept;
  logic             pop;

  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] head_tag;

  // ---------------------------------------------------------------------------
  // Arbitration: scan from last_grant+1 upward, wrapping at NREQ; first valid
  // requester wins.
  // ---------------------------------------------------------------------------
  always_comb begin : rr_arbiter
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
`ifdef CORDIC_SCHED_HIPRIO_EN
    // Requester 0 overrides the rotation. When it is idle, the scan above
    // already covers the remaining requesters in round-robin order.
    if (req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`else
`endif
  end

  // The winner's payload is selected with a compare mux so that indexing
  // never depends on an arithmetic slice base.
  always_comb begin : payload_mux
    sel_mode = '0;
    sel_arg  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_mode = req_mode[4*i +: 4];
        sel_arg  = req_arg[32*i +: 32];
      end
    end
  end

  // A pop in the same cycle does not free a slot in time to accept, so a full
  // FIFO blocks everyone regardless of cor_post_valid.
  assign full     = (inflight == FULL_CNT);
  assign accept   = grant_any && !full;
  assign pop      = cor_post_valid && (inflight != '0);
  assign head_tag = tag_mem[rd_ptr];

  // NOTE: every variable an always_comb writes gets a default at the top of
  // the block. Otherwise a path that skips the assignment infers a latch.
  always_comb begin : ready_gen
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Tag storage
  // NOTE: the tag array has no reset. Only the pointers and the occupancy
  // define which entries are live, so stale contents are never observed, and
  // leaving the array unreset lets it map onto plain RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= grant_idx;
  end

  // ---------------------------------------------------------------------------
  // Control and datapath state
  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values. The later rsp_valid bit-set then overrides the
  // earlier clear within the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= LAST_IDX;
      cor_pre_valid <= 1'b0;
      cor_mode      <= '0;
      cor_angle     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= '0;
      err_orphan    <= 1'b0;
    end else begin
      cor_pre_valid <= accept;
      if (accept) begin
        cor_mode   <= sel_mode;
        cor_angle  <= sel_arg;
        last_grant <= grant_idx;
        wr_ptr     <= wr_ptr + 1'b1;
      end

      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[head_tag] <= 1'b1;
        rsp_result          <= cor_result;
        rd_ptr              <= rd_ptr + 1'b1;
      end

      // A result with nothing outstanding cannot be routed; flag it for good.
      if (cor_post_valid && (inflight == '0)) err_orphan <= 1'b1;

      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// -----------------------------------------------------------------------------
// tb_cordic_sched
//   Directed bench for cordic_sched with NREQ=4, TAG_DEPTH=32. The core result
//   path is either driven by hand or by a small in-order core model whose
//   latency is set per test. That model returns the bitwise inverse of the
//   issued angle.
// -----------------------------------------------------------------------------
module tb_cordic_sched;

  localparam int NREQ      = 4;
  localparam int TAG_DEPTH = 32;

  logic                        clk;
  logic                        rst_n;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [4*NREQ-1:0]           req_mode;
  logic [32*NREQ-1:0]          req_arg;
  logic [NREQ-1:0]             rsp_valid;
  logic [31:0]                 rsp_result;
  logic                        cor_pre_valid;
  logic [3:0]                  cor_mode;
  logic [31:0]                 cor_angle;
  logic [31:0]                 cor_result;
  logic                        cor_post_valid;
  logic [$clog2(TAG_DEPTH):0]  inflight;
  logic                        err_orphan;

  cordic_sched #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mode      (req_mode),
    .req_arg       (req_arg),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .cor_pre_valid (cor_pre_valid),
    .cor_mode      (cor_mode),
    .cor_angle     (cor_angle),
    .cor_result    (cor_result),
    .cor_post_valid(cor_post_valid),
    .inflight      (inflight),
    .err_orphan    (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Core model: in-order delay line, result = ~angle
  // ---------------------------------------------------------------------------
  logic        model_en;
  int          lat;
  logic        man_pv;
  logic [31:0] man_res;
  logic        pipe_v [64];
  logic [31:0] pipe_d [64];

  always @(posedge clk) begin
    if (!model_en) begin
      for (int i = 0; i < 64; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= cor_pre_valid;
      pipe_d[0] <= ~cor_angle;
      for (int i = 1; i < 64; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign cor_post_valid = model_en ? pipe_v[lat-1] : man_pv;
  assign cor_result     = model_en ? pipe_d[lat-1] : man_res;

  // ---------------------------------------------------------------------------
  // Checking and helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] m, input logic [31:0] a);
    req_valid[i]        = v;
    req_mode[4*i +: 4]  = m;
    req_arg[32*i +: 32] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Round-robin response collection state
  int rr_got;

  task automatic rr_collect();
    logic [31:0] exp_res;
    if (rsp_valid != '0) begin
      if (rr_got < 8) begin
        exp_res = ~(32'h0001_0000 * (rr_got % 4 + 1));
        check("rr_rsp_tag", rsp_valid, 64'(1) << (rr_got % 4));
        check("rr_rsp_result", rsp_result, exp_res);
      end else begin
        check("rr_rsp_extra", rsp_valid, 0);
      end
      rr_got++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int accepts_early, stall_len, first_pv, late_acc, w;
    logic acc;

    rst_n     = 1'b0;
    req_valid = '0;
    req_mode  = '0;
    req_arg   = '0;
    model_en  = 1'b0;
    lat       = 1;
    man_pv    = 1'b0;
    man_res   = '0;

    // ---- Reset state ----
    tick();
    tick();
    check("rst_pre_valid", cor_pre_valid, 0);
    check("rst_mode",      cor_mode, 0);
    check("rst_angle",     cor_angle, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_res",   rsp_result, 0);
    check("rst_inflight",  inflight, 0);
    check("rst_orphan",    err_orphan, 0);
    // The grant may show during reset (search starts after last_grant=3), but
    // nothing is accepted.
    set_req(1, 1'b1, 4'h9, 32'h1111_1111);
    settle();
    check("rst_ready_comb", req_ready, 4'b0010);
    tick();
    check("rst_no_accept", inflight, 0);
    check("rst_no_issue",  cor_pre_valid, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // ---- Single request: 30.0 in, 32768 back ----
    set_req(0, 1'b1, 4'h0, 32'd1966080);
    settle();
    check("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("single_issue",    cor_pre_valid, 1);
    check("single_angle",    cor_angle, 32'd1966080);
    check("single_mode",     cor_mode, 0);
    check("single_inflight", inflight, 1);
    tick();
    check("single_issue_off",  cor_pre_valid, 0);
    check("single_angle_hold", cor_angle, 32'd1966080);
    man_pv  = 1'b1;
    man_res = 32'd32768;
    tick();
    man_pv = 1'b0;
    check("single_rsp_valid", rsp_valid, 4'b0001);
    check("single_rsp_res",   rsp_result, 32'd32768);
    check("single_drained",   inflight, 0);
    check("single_no_orphan", err_orphan, 0);
    tick();
    check("single_rsp_pulse", rsp_valid, 0);

`ifndef CORDIC_SCHED_HIPRIO_EN
    // ---- Round-robin, all four valid after reset ----
    do_reset();
    lat      = 3;
    model_en = 1'b1;
    rr_got   = 0;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 4'(i + 1), 32'h0001_0000 * (i + 1));
    for (int k = 0; k < 8; k++) begin
      settle();
      check("rr_grant", req_ready, 64'(1) << (k % 4));
      tick();
      check("rr_issue", cor_pre_valid, 1);
      check("rr_mode",  cor_mode, 64'(k % 4 + 1));
      rr_collect();
    end
    req_valid = '0;
    for (int c = 0; c < 20 && rr_got < 8; c++) begin
      tick();
      rr_collect();
    end
    check("rr_rsp_count", rr_got, 8);
    tick();
    tick();
    model_en = 1'b0;
`else
    // ---- Priority requester 0 ----
    do_reset();
    set_req(0, 1'b1, 4'h1, 32'h0000_0A00);
    set_req(2, 1'b1, 4'h2, 32'h0000_0C00);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("hp_grant0", req_ready, 4'b0001);
      tick();
      check("hp_angle0", cor_angle, 32'h0000_0A00);
    end
    set_req(0, 1'b0, 4'h1, 32'h0000_0A00);
    settle();
    check("hp_grant2", req_ready, 4'b0100);
    tick();
    check("hp_angle2", cor_angle, 32'h0000_0C00);
    req_valid = '0;
`endif

    // ---- Fill to TAG_DEPTH with a 40-cycle core ----
    do_reset();
    lat      = 40;
    model_en = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 4'h7, 32'h0000_0100 * (i + 1));
    accepts_early = 0;
    stall_len     = 0;
    first_pv      = -1;
    late_acc      = 0;
    for (int c = 0; c < 60; c++) begin
      settle();
      acc = |(req_valid & req_ready);
      if (c < 32 && acc) accepts_early++;
      if (c >= 32 && c <= 41 && req_ready == '0) stall_len++;
      if (first_pv < 0 && cor_post_valid) first_pv = c;
      if (c >= 42 && acc) late_acc++;
      if (c == 36) check("full_inflight", inflight, 32);
      if (c == 41) check("full_pop_blocked", req_ready, 0);
      tick();
    end
    check("full_accepts",    accepts_early, 32);
    check("full_stall_len",  stall_len, 10);
    check("full_first_pv",   first_pv, 41);
    check("full_late_acc",   late_acc, 18);
    check("full_steady_cnt", inflight, 31);
    check("full_no_orphan",  err_orphan, 0);
    req_valid = '0;
    w = 0;
    while (inflight != 0 && w < 100) begin
      tick();
      w++;
    end
    check("full_drain", inflight, 0);
    tick();
    model_en = 1'b0;
    tick();

    // ---- Orphan result ----
    check("orphan_pre", inflight, 0);
    man_pv  = 1'b1;
    man_res = 32'h0000_DEAD;
    tick();
    man_pv = 1'b0;
    check("orphan_no_rsp", rsp_valid, 0);
    check("orphan_flag",   err_orphan, 1);
    tick();
    tick();
    check("orphan_sticky",  err_orphan, 1);
    check("orphan_no_rsp2", rsp_valid, 0);
    rst_n = 1'b0;
    settle();
    check("orphan_cleared", err_orphan, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- Reset with five operations in flight ----
    set_req(0, 1'b1, 4'h3, 32'h0000_0100);
    for (int k = 0; k < 5; k++) tick();
    req_valid = '0;
    check("mid_inflight", inflight, 5);
    check("mid_issue",    cor_pre_valid, 1);
    rst_n = 1'b0;
    settle();
    check("mid_rst_issue",    cor_pre_valid, 0);
    check("mid_rst_mode",     cor_mode, 0);
    check("mid_rst_angle",    cor_angle, 0);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_rsp",      rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      man_pv  = 1'b1;
      man_res = 32'(k);
      tick();
      check("stale_no_rsp", rsp_valid, 0);
    end
    man_pv = 1'b0;
    tick();
    check("stale_no_rsp_end", rsp_valid, 0);
    check("stale_orphan",     err_orphan, 1);
    check("stale_inflight",   inflight, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
